// File: rtl/ppu_data_port.sv
// PPU data port: $2006 pointer load, $2007 VRAM/palette access, shared write toggle.
// $2007 access takes one extra cycle (busy=1); strobes arriving while busy are dropped.
module ppu_data_port #(
   parameter int unsigned ADDR_W      = 14,
   parameter logic [5:0]  PAL_BASE_HI = 6'h3F
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        cpu_sel,
   input  logic              cpu_wr,
   input  logic              cpu_rd,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   input  logic              inc32,
   output logic              busy,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_dout,
   output logic              vram_we,
   input  logic [7:0]        vram_din,
   output logic [4:0]        pal_addr,
   output logic [7:0]        pal_dout,
   output logic              pal_we,
   input  logic [7:0]        pal_din
);

   localparam logic [2:0] SEL_STATUS = 3'd2;
   localparam logic [2:0] SEL_SCROLL = 3'd5;
   localparam logic [2:0] SEL_ADDR   = 3'd6;
   localparam logic [2:0] SEL_DATA   = 3'd7;

   typedef enum logic [1:0] {IDLE, WRITE, FETCH} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   v;
   logic [ADDR_W-9:0]   t_hi;
   logic                w;
   logic [7:0]          read_buf;
   logic [7:0]          wdata;
   logic                pal_hit;
   logic [4:0]          pal_idx;
   logic [ADDR_W-1:0]   v_step;
   logic                is_idle;
   logic                wr_acc;
   logic                rd_acc;

   assign is_idle = (state == IDLE);
   // Write wins over a simultaneous read; nothing is accepted mid-access.
   assign wr_acc  = is_idle && cpu_wr;
   assign rd_acc  = is_idle && cpu_rd && !cpu_wr;

   assign pal_hit = (v[ADDR_W-1 -: 6] == PAL_BASE_HI);
   assign pal_idx = v[4:0];
   // Sprite backdrop entries 10/14/18/1C alias the background ones.
   assign pal_addr = (pal_idx[4] && (pal_idx[1:0] == 2'b00)) ? {1'b0, pal_idx[3:0]} : pal_idx;

   assign v_step    = inc32 ? ADDR_W'(32) : ADDR_W'(1);
   assign vram_addr = v;
   assign vram_dout = wdata;
   assign pal_dout  = wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (wr_acc && (cpu_sel == SEL_DATA)) begin
               state_nxt = WRITE;
            end else if (rd_acc && (cpu_sel == SEL_DATA)) begin
               state_nxt = FETCH;
            end
         end
         WRITE:   state_nxt = IDLE;
         FETCH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      vram_we = 1'b0;
      pal_we  = 1'b0;
      case (state)
         WRITE: begin
            busy    = 1'b1;
            vram_we = !pal_hit;
            pal_we  = pal_hit;
         end
         FETCH:   busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v        <= '0;
         t_hi     <= '0;
         w        <= 1'b0;
         read_buf <= 8'h00;
         wdata    <= 8'h00;
         cpu_dout <= 8'h00;
      end else begin
         if (wr_acc) begin
            case (cpu_sel)
               SEL_ADDR: begin
                  if (!w) begin
                     t_hi <= cpu_din[ADDR_W-9:0];
                  end else begin
                     v <= {t_hi, cpu_din};
                  end
                  w <= !w;
               end
               SEL_SCROLL: w <= !w;
               SEL_DATA:   wdata <= cpu_din;
               default:    ;
            endcase
         end
         if (rd_acc && (cpu_sel == SEL_STATUS)) begin
            w <= 1'b0;
         end
         // Palette reads bypass the buffer but still refresh it from VRAM.
         if (state == FETCH) begin
            cpu_dout <= pal_hit ? pal_din : read_buf;
            read_buf <= vram_din;
         end
         if (!is_idle) begin
            v <= v + v_step;
         end
      end
   end

endmodule

// File: doc/ppu_data_port.md
Name: ppu_data_port

Overview:
- CPU-facing PPU data-port controller for PPUADDR ($2006), PPUDATA ($2007), the shared write-toggle latch, and the $2002-read latch clear.
- Holds the 14-bit VRAM address pointer and steers each $2007 access to VRAM or to the palette memory.
- Performs the buffered-read and auto-increment sequencing.
- Sits directly upstream of the palette memory and drives its addr/data_in/WE.

Parameters:
- ADDR_W, 14, VRAM address pointer width.
- PAL_BASE_HI, 6'h3F, value of pointer[13:8] that selects palette space.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- cpu_sel  input  3  PPU register select (CPU address bits [2:0]).
- cpu_wr  input  1  one-cycle CPU write strobe.
- cpu_rd  input  1  one-cycle CPU read strobe.
- cpu_din  input  8  CPU write data.
- cpu_dout  output  8  registered $2007 read result.
- inc32  input  1  PPUCTRL bit 2; 1 = increment by 32, 0 = increment by 1.
- busy  output  1  high while a $2007 access is in flight.
- vram_addr  output  14  current pointer v.
- vram_dout  output  8  VRAM write data.
- vram_we  output  1  VRAM write enable, one cycle.
- vram_din  input  8  VRAM read data, combinational from vram_addr.
- pal_addr  output  5  palette address.
- pal_dout  output  8  palette write data.
- pal_we  output  1  palette write enable, one cycle.
- pal_din  input  8  palette read data, combinational from pal_addr.

Behaviour:
- Reset (async, low): v=0, t=0, w=0, read_buf=0, wdata=0, state=IDLE. Outputs: cpu_dout=0, busy=0, vram_we=0, pal_we=0, vram_addr=0, pal_addr=0, vram_dout=0, pal_dout=0. Reset mid-access aborts it; strobes drop immediately; no increment.
- Palette select: pal_hit = (v[13:8]==PAL_BASE_HI).
- Palette address mapping: pal_addr = v[4:0], except 5'h10/14/18/1C map to 5'h00/04/08/0C, for both reads and writes.
- vram_addr = v continuously. vram_dout = pal_dout = wdata.
- $2006 write (in IDLE):
  - w=0: t[13:8] <= cpu_din[5:0].
  - w=1: t[7:0] <= cpu_din and v <= {t[13:8], cpu_din}; v updates at the same edge.
  - w toggles on each write.
- $2005 write: toggles w only.
- $2002 read: w <= 0. cpu_dout unchanged.
- Other registers/strobes: ignored.
- State machine (IDLE, WRITE, FETCH):
  - IDLE + cpu_wr to $2007 at cycle N: wdata <= cpu_din; go WRITE.
  - WRITE (cycle N+1): busy=1. pal_we=pal_hit, vram_we=!pal_hit, for exactly this cycle. At cycle end, v <= v + (inc32 ? 32 : 1) modulo 2^14; return to IDLE.
  - IDLE + cpu_rd of $2007 at cycle N: go FETCH.
  - FETCH (cycle N+1): busy=1.
    - Non-palette: cpu_dout <= read_buf; read_buf <= vram_din.
    - Palette: cpu_dout <= pal_din; read_buf <= vram_din. The underlying VRAM byte is read at the same v; external mirroring is not this block's concern.
    - Then increment v as in WRITE; return to IDLE.
  - cpu_dout is valid from cycle N+2 and held until the next $2007 read.
- Any cpu_wr/cpu_rd while busy=1 is dropped with no side effects (no w toggle).
- Simultaneous cpu_wr and cpu_rd in one cycle: write wins; read ignored.
- Pointer wrap: 14'h3FFF + 1 -> 14'h0000; 14'h3FF0 + 32 -> 14'h0010.
- $2006 writes land only in IDLE; a completed second write takes effect before any following $2007 access.

Test Plan:
- Reset low mid-WRITE -> vram_we/pal_we drop immediately; v=0, w=0, cpu_dout=0 after release.
- $2006 writes 3F, 10; $2007 write 8'h2A -> next cycle pal_we=1, pal_addr=5'h00, pal_dout=2A; then vram_addr=14'h3F11.
- $2006 writes 20, 00; inc32=1; two $2007 writes 11, 22 -> vram_we pulses at 14'h2000 then 14'h2020; final v=14'h2040.
- VRAM[2400]=AB, [2401]=CD; $2006 writes 24, 00; three $2007 reads -> cpu_dout = 00 (stale buffer), AB, CD; each valid 2 cycles after its strobe.
- $2006 write 3F only, then $2002 read, then $2006 writes 21, 05 -> v=14'h2105 (latch cleared); palette read at 3F04 (pal_din=17) -> cpu_dout=17 with no buffer delay.
- v=14'h3FFF, inc32=0, $2007 write; second cpu_wr issued while busy -> exactly one pal_we; v=14'h0000.
